// File: rtl/mem_access_unit.sv
// Load/store front end for the byte-addressed toy RAM: alignment/range checks,
// read-modify-write for sub-word stores, sign/zero-extended load results.
module mem_access_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned MEM_SIZE   = 16384,
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [1:0]            resp_err,
  output logic                  ram_read,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_dat_in,
  input  logic [DATA_WIDTH-1:0] ram_dat_out,
  input  logic                  ram_available,
  input  logic                  ram_conflict_err
);

  localparam int unsigned AW1 = ADDR_WIDTH + 1;
  localparam int unsigned CW  = $clog2(WAIT_LIMIT + 1);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_RAM   = 2'b11;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                  state;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    uns_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    err_q;
  logic [CW-1:0]           wait_cnt;

  logic [2:0]              nbytes_c;
  logic [AW1-1:0]          last_byte_c;
  logic                    range_err_c;
  logic                    align_err_c;
  logic                    ram_err_c;

  // Unwrapped address of the last byte touched, for the range check
  always_comb begin
    nbytes_c = 3'd4;
    case (req_size)
      2'b00:   nbytes_c = 3'd1;
      2'b01:   nbytes_c = 3'd2;
      default: nbytes_c = 3'd4;
    endcase
    last_byte_c = {1'b0, req_addr} + AW1'(nbytes_c) - AW1'(1);
    range_err_c = (req_size == 2'b11) || (last_byte_c >= AW1'(MEM_SIZE));
    align_err_c = ((req_size == 2'b01) && req_addr[0]) ||
                  ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  assign ram_err_c = err_q | ram_conflict_err;
  assign req_ready = (state == IDLE) & ~rst;

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
    case (sz)
      2'b00:   load_ext = {{24{d[7] & ~uns}}, d[7:0]};
      2'b01:   load_ext = {{16{d[15] & ~uns}}, d[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                        input logic [1:0] sz);
    case (sz)
      2'b00:   merge = {old[31:8], w[7:0]};
      2'b01:   merge = {old[31:16], w[15:0]};
      default: merge = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      wait_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_OK;
      ram_read   <= 1'b0;
      ram_write  <= 1'b0;
      ram_addr   <= '0;
      ram_dat_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            uns_q    <= req_unsigned;
            wdata_q  <= req_wdata;
            err_q    <= 1'b0;
            wait_cnt <= '0;
            if (range_err_c || align_err_c) begin
              resp_valid <= 1'b1;
              resp_rdata <= '0;
              resp_err   <= range_err_c ? ERR_RANGE : ERR_ALIGN;
              state      <= RESP;
            end else begin
              ram_addr <= req_addr;
              // Full-word stores skip the read; everything else reads first
              if (req_we && (req_size == 2'b10)) begin
                ram_write  <= 1'b1;
                ram_dat_in <= req_wdata;
                state      <= WRITE;
              end else begin
                ram_read <= 1'b1;
                state    <= READ;
              end
            end
          end
        end
        READ: begin
          err_q <= ram_err_c;
          if (ram_available) begin
            ram_read <= 1'b0;
            if (we_q) begin
              ram_write  <= 1'b1;
              ram_dat_in <= merge(ram_dat_out, wdata_q, size_q);
              state      <= WRITE;
            end else begin
              resp_valid <= 1'b1;
              resp_err   <= ram_err_c ? ERR_RAM : ERR_OK;
              resp_rdata <= ram_err_c ? '0 : load_ext(ram_dat_out, size_q, uns_q);
              state      <= RESP;
            end
          end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
            ram_read   <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= ERR_RAM;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        WRITE: begin
          ram_write  <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= ram_err_c ? ERR_RAM : ERR_OK;
          resp_rdata <= '0;
          state      <= RESP;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= ERR_OK;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed plan plus random ops against a byte-array
// reference memory; also models the RAM side (read latency, conflicts).
module tb_mem_access_unit;

  localparam int unsigned AW = 16;
  localparam int MS = 16384;
  localparam int WL = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        ram_read, ram_write;
  logic [15:0] ram_addr;
  logic [31:0] ram_dat_in, ram_dat_out;
  logic        ram_available, ram_conflict_err;

  logic [7:0] ram_mem [MS+4];
  logic [7:0] ref_mem [MS+4];

  int checks = 0;
  int failures = 0;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_dat_in(ram_dat_in), .ram_dat_out(ram_dat_out),
    .ram_available(ram_available), .ram_conflict_err(ram_conflict_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input int a);
    return {ram_mem[a+3], ram_mem[a+2], ram_mem[a+1], ram_mem[a]};
  endfunction

  function automatic logic [31:0] ref_word(input int a);
    return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
  endfunction

  task automatic preload(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ram_mem[a+i] = w[8*i +: 8];
      ref_mem[a+i] = w[8*i +: 8];
    end
  endtask

  // Reference: what a single request should produce, from the rules alone
  task automatic model(input bit we, input logic [1:0] size, input bit uns, input int addr,
                       input logic [31:0] wdata, input int delay, input int conflict_at,
                       output logic [1:0] e_err, output logic [31:0] e_rdata,
                       output int e_reads, output int e_writes, output logic [31:0] e_wdat,
                       output int lat_min, output int lat_max);
    int nb;
    logic [31:0] old, mask, val;
    bit hard;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    e_rdata = 32'h0; e_reads = 0; e_writes = 0; e_wdat = 32'h0; e_err = 2'd0;
    if (size == 2'd3 || addr + nb - 1 >= MS) begin
      e_err = 2'd2; lat_min = 1; lat_max = 1;
    end else if (addr % nb != 0) begin
      e_err = 2'd1; lat_min = 1; lat_max = 1;
    end else if (we && nb == 4) begin
      e_writes = 1; e_wdat = wdata; lat_min = 2; lat_max = 2;
      e_err = (conflict_at == 0) ? 2'd3 : 2'd0;
      for (int i = 0; i < 4; i++) ref_mem[addr+i] = wdata[8*i +: 8];
    end else if (delay >= WL) begin
      e_err = 2'd3; e_reads = -1; lat_min = WL + 1; lat_max = WL + 2;
    end else begin
      hard = (conflict_at >= 0) && (conflict_at <= delay + (we ? 1 : 0));
      e_err = hard ? 2'd3 : 2'd0;
      e_reads = delay + 1;
      old = ref_word(addr);
      mask = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      if (we) begin
        e_wdat = (old & ~mask) | (wdata & mask);
        e_writes = 1;
        for (int i = 0; i < nb; i++) ref_mem[addr+i] = wdata[8*i +: 8];
        lat_min = 3 + delay; lat_max = lat_min;
      end else begin
        val = old & mask;
        if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
        e_rdata = hard ? 32'h0 : val;
        lat_min = 2 + delay; lat_max = lat_min;
      end
    end
  endtask

  // Drives one request and plays the RAM until the response (or a cycle bound)
  task automatic run_op(input bit we, input logic [1:0] size, input bit uns, input int addr,
                        input logic [31:0] wdata, input int delay, input int conflict_at,
                        output int lat, output logic [31:0] rdata, output logic [1:0] err,
                        output int nreads, output int nwrites, output logic [31:0] wdat);
    int strobes;
    strobes = 0; nreads = 0; nwrites = 0; lat = -1;
    rdata = 32'hx; err = 2'bx; wdat = 32'h0;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = AW'(addr); req_wdata = wdata;
    @(posedge clk);
    for (int cyc = 1; cyc <= WL + 10; cyc++) begin
      @(negedge clk);
      req_valid = 1'b0; req_wdata = $urandom; req_addr = AW'($urandom);
      req_size = 2'($urandom); req_we = 1'($urandom);
      ram_conflict_err = 1'b0;
      if (ram_read || ram_write) begin
        if (strobes == conflict_at) ram_conflict_err = 1'b1;
        strobes++;
      end
      if (ram_read) begin
        nreads++;
        ram_dat_out = ram_word(int'(ram_addr));
        ram_available = (nreads > delay);
      end else begin
        ram_available = 1'($urandom_range(0, 1));
        ram_dat_out = $urandom;
      end
      if (ram_write) begin
        nwrites++;
        wdat = ram_dat_in;
        check("write_addr", 32'(ram_addr), 32'(addr));
        for (int i = 0; i < 4; i++) ram_mem[int'(ram_addr)+i] = ram_dat_in[8*i +: 8];
      end
      if (resp_valid) begin
        lat = cyc; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
    ram_available = 1'b0; ram_conflict_err = 1'b0; req_valid = 1'b0;
  endtask

  task automatic do_op(input string tag, input bit we, input logic [1:0] size, input bit uns,
                       input int addr, input logic [31:0] wdata, input int delay,
                       input int conflict_at);
    logic [1:0] e_err, err;
    logic [31:0] e_rdata, e_wdat, rdata, wdat;
    int e_reads, e_writes, lat_min, lat_max, lat, nreads, nwrites;
    model(we, size, uns, addr, wdata, delay, conflict_at, e_err, e_rdata, e_reads, e_writes,
          e_wdat, lat_min, lat_max);
    run_op(we, size, uns, addr, wdata, delay, conflict_at, lat, rdata, err, nreads, nwrites, wdat);
    if (lat < 0) check({tag, "_resp_timeout"}, 32'd0, 32'd1);
    else begin
      if (lat_min == lat_max) check({tag, "_latency"}, 32'(lat), 32'(lat_min));
      else check({tag, $sformatf("_latency_range(lat=%0d)", lat)},
                 32'(lat >= lat_min && lat <= lat_max), 32'd1);
      check({tag, "_err"}, 32'(err), 32'(e_err));
      check({tag, "_rdata"}, rdata, e_rdata);
      check({tag, "_writes"}, 32'(nwrites), 32'(e_writes));
      if (e_reads >= 0) check({tag, "_reads"}, 32'(nreads), 32'(e_reads));
      if (e_writes == 1) check({tag, "_wdat"}, wdat, e_wdat);
    end
  endtask

  initial begin
    bit we, uns;
    logic [1:0] sz;
    int addr, delay, conf;
    for (int i = 0; i < MS + 4; i++) begin ram_mem[i] = 8'h0; ref_mem[i] = 8'h0; end
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; ram_dat_out = '0; ram_available = 1'b0;
    ram_conflict_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_strobes", 32'({ram_read, ram_write}), 32'd0);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    check("rst_resp", {resp_rdata[29:0], resp_err}, 32'd0);
    rst = 1'b0;

    // Directed plan
    do_op("sw_deadbeef", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, -1);
    do_op("lw_deadbeef", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, -1);
    preload(32'h20, 32'h0000_80F0);
    do_op("lb", 1'b0, 2'd0, 1'b0, 32'h20, 32'h0, 0, -1);
    do_op("lbu", 1'b0, 2'd0, 1'b1, 32'h20, 32'h0, 1, -1);
    do_op("lh", 1'b0, 2'd1, 1'b0, 32'h20, 32'h0, 0, -1);
    do_op("lhu", 1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 2, -1);
    preload(32'h30, 32'h1122_3344);
    do_op("sb_rmw", 1'b1, 2'd0, 1'b0, 32'h30, 32'h0000_00AB, 0, -1);
    do_op("lw_after_sb", 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 0, -1);
    do_op("sh_rmw", 1'b1, 2'd1, 1'b0, 32'h32, 32'hCAFE_BEEF, 1, -1);
    do_op("lh_misaligned", 1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 0, -1);
    do_op("lw_past_end", 1'b0, 2'd2, 1'b0, MS - 2, 32'h0, 0, -1);
    do_op("lw_last_word", 1'b0, 2'd2, 1'b0, MS - 4, 32'h0, 0, -1);
    do_op("lb_last_byte", 1'b0, 2'd0, 1'b0, MS - 1, 32'h0, 0, -1);
    do_op("size_11", 1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 0, -1);
    do_op("ram_timeout", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 40, -1);
    do_op("sw_conflict", 1'b1, 2'd2, 1'b0, 32'h44, 32'h1234_5678, 0, 0);
    do_op("lw_conflict", 1'b0, 2'd2, 1'b0, 32'h44, 32'h0, 2, 1);
    do_op("sb_conflict_wr", 1'b1, 2'd0, 1'b0, 32'h45, 32'h0000_0099, 1, 2);

    // Reset in the middle of a read
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 16'h0010;
    @(negedge clk);
    req_valid = 1'b0; ram_available = 1'b0;
    @(negedge clk);
    check("mid_read_strobe", 32'(ram_read), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_drops_read", 32'(ram_read), 32'd0);
    check("rst_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_rst_no_resp", 32'(resp_valid), 32'd0);
      check("post_rst_ready", 32'(req_ready), 32'd1);
    end

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      we = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 7) == 0) ? MS - int'($urandom_range(1, 6))
                                         : int'($urandom_range(0, 63));
      delay = int'($urandom_range(0, 3));
      conf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 4)) : -1;
      do_op($sformatf("rand%0d", n), we, sz, uns, addr, $urandom, delay, conf);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end between the CPU execute stage and the byte-addressed toy RAM.
- Accepts one byte/half/word load or store at a time and checks alignment and range.
- Sequences RAM read/write strobes, doing read-modify-write for sub-word stores because the RAM writes a full 32-bit word.
- Returns sign/zero-extended load data and an error code.

Parameters:
DATA_WIDTH, 32, data width; fixed at 32
ADDR_WIDTH, 16, byte address width
MEM_SIZE, 16384, RAM size in bytes; highest legal byte is MEM_SIZE-1
WAIT_LIMIT, 15, max cycles waiting for ram_available before a timeout error

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data; low bytes used for sub-word stores
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  2  00 ok, 01 misaligned, 10 range/illegal size, 11 RAM error
ram_read  out  1  RAM read strobe
ram_write  out  1  RAM write strobe
ram_addr  out  ADDR_WIDTH  RAM byte address
ram_dat_in  out  32  write data to RAM (little-endian: bits 7:0 at ram_addr)
ram_dat_out  in  32  read data from RAM
ram_available  in  1  RAM read data valid this cycle
ram_conflict_err  in  1  RAM signals access conflict

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- req_ready = (state==IDLE) & ~rst. Handshake occurs on req_valid & req_ready; all request fields are captured on that edge.
- While rst=1: state=IDLE; resp_valid, ram_read and ram_write are 0; resp_rdata, resp_err, ram_addr and ram_dat_in are 0. An in-flight access is abandoned with no response, and strobes drop immediately.
- Checks at acceptance, in priority order:
  - req_size==11, or req_addr + bytes - 1 >= MEM_SIZE (computed in ADDR_WIDTH+1 bits, no wrap) -> err 10.
  - Half with addr[0]!=0, or word with addr[1:0]!=0 -> err 01.
  - Any error -> RESP directly; no RAM strobe is ever issued.
- Routing after acceptance:
  - Load or sub-word store -> READ.
  - Word store -> WRITE with ram_dat_in=req_wdata.
- READ:
  - ram_read=1 and ram_addr=captured address every cycle in this state.
  - On ram_available=1, latch ram_dat_out.
  - Load -> RESP.
  - Sub-word store -> WRITE. Merged word replaces the low byte (SB) or low half (SH) of the read data with req_wdata's low byte/half; the upper bytes are preserved.
  - Wait counter reaching WAIT_LIMIT without ram_available -> RESP with err 11.
- WRITE: ram_write=1 for exactly one cycle with ram_addr and ram_dat_in valid, then RESP.
- ram_conflict_err=1 in any READ/WRITE cycle -> err 11 (sticky for this request). The FSM still finishes normally to RESP.
- RESP: resp_valid=1 for one cycle, then IDLE.
  - Loads: resp_rdata is the byte, half or word, extended per req_unsigned; word ignores req_unsigned.
  - Stores and errors: resp_rdata=0.
- Latency with ram_available=1 on first READ cycle (accept at edge T):
  - Load: resp at T+2.
  - Word store: resp at T+2.
  - Sub-word store: resp at T+3.
  - Error: resp at T+1.
- ram_available while not in READ is ignored. No new request is accepted until RESP completes; back-to-back requests need a gap of one IDLE cycle at minimum.

Test Plan:
- Word load/store:
  - Store word 0xDEADBEEF at 0x0010 -> one ram_write cycle with ram_dat_in=0xDEADBEEF, resp_err=00.
  - LW at 0x0010 -> resp_rdata=0xDEADBEEF, resp_valid 2 cycles after accept.
- Sign/zero extension: memory word 0x000080F0 at 0x0020.
  - LB -> 0xFFFFFFF0.
  - LBU -> 0x000000F0.
  - LH -> 0xFFFF80F0.
  - LHU -> 0x000080F0.
- SB read-modify-write: memory word 0x11223344 at 0x0030, SB wdata 0xAB -> ram_read then ram_write with ram_dat_in=0x112233AB, resp at T+3.
- Faults:
  - LH at 0x0031 -> err 01, no strobes.
  - LW at MEM_SIZE-2 -> err 10.
  - req_size=11 -> err 10.
- RAM misbehaviour:
  - Hold ram_available=0 -> after WAIT_LIMIT cycles, resp err 11.
  - ram_conflict_err pulse during a write -> err 11.
- Reset: assert rst mid-READ -> ram_read drops the same cycle, no resp_valid, req_ready=1 the cycle after rst falls.
